// File: rtl/ps2_event_pkg.sv
// Shared types and scan-code constants for the PS/2 event controller.
// Imported by the event FIFO and the top-level controller.
package ps2_event_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_SETTLE
  } fetch_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Shift-register event FIFO; entry 0 is the head, so head outputs are flops.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module ps2_event_fifo
  import ps2_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  kb_event_t din,
  output kb_event_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  kb_event_t       mem [DEPTH];
  logic [CW-1:0]   cnt;
  logic            do_pop;
  logic            do_push;
  logic [CW-1:0]   wr_pos;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);
  assign wr_pos  = do_pop ? cnt - CW'(1) : cnt;

  assign head  = mem[0];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++)
          mem[i] <= mem[i+1];
        mem[DEPTH-1] <= '0;
      end
      // Write lands after the shift so it wins on a shared slot.
      if (do_push)
        mem[wr_pos[AW-1:0]] <= din;
      if (do_push && !do_pop)
        cnt <= cnt + CW'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_event_ctrl.sv
// PS/2 byte fetch, prefix decode, held-key tracking and event queueing.
// One receiver byte is consumed every three cycles at most.
module ps2_event_ctrl
  import ps2_event_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       mainclk,
  input  logic       reset,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ack,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [8:0] held_cnt,
  output logic [7:0] drop_cnt,
  output logic       kb_ovf_seen
);

  fetch_state_t state;
  logic [7:0]   byte_q;
  logic         ext_pend;
  logic         brk_pend;
  logic [2:0]   skip_cnt;
  logic [255:0] held;

  logic         key_byte;
  logic [7:0]   idx;
  logic         is_held;
  logic         push;
  logic         set_key;
  logic         clr_key;
  kb_event_t    push_ev;
  kb_event_t    head;
  logic         full;
  logic         empty;
  logic         pop;
  logic         drop;

  assign key_byte = (state == S_POP) && (skip_cnt == '0) && !byte_q[7];
  assign idx      = {ext_pend, byte_q[6:0]};
  assign is_held  = held[idx];

  always_comb begin
    push    = 1'b0;
    set_key = 1'b0;
    clr_key = 1'b0;
    push_ev = '{ext: ext_pend, brk: brk_pend, code: byte_q};
    if (key_byte) begin
      if (!brk_pend) begin
        if (!is_held) begin
          set_key = 1'b1;
          push    = 1'b1;
        end else begin
          push = (SUPPRESS_REPEAT == 0);
        end
      end else if (is_held) begin
        clr_key = 1'b1;
        push    = 1'b1;
      end
    end
  end

  assign pop  = ev_ack && !empty;
  assign drop = push && full && !pop;

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (mainclk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (push_ev),
    .head (head),
    .full (full),
    .empty(empty)
  );

  assign ev_valid = !empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;

  always_ff @(posedge mainclk) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_q        <= '0;
      kb_nextdata_n <= 1'b1;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      skip_cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (kb_ready) begin
            byte_q        <= kb_data;
            kb_nextdata_n <= 1'b0;
            state         <= S_POP;
          end
        end
        S_POP: begin
          kb_nextdata_n <= 1'b1;
          state         <= S_SETTLE;
          if (skip_cnt != '0) begin
            skip_cnt <= skip_cnt - 3'd1;
          end else if (byte_q == SC_PAUSE) begin
            skip_cnt <= PAUSE_SKIP;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else if (byte_q == SC_EXT) begin
            ext_pend <= 1'b1;
          end else if (byte_q == SC_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        S_SETTLE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mainclk) begin
    if (reset) begin
      held        <= '0;
      held_cnt    <= '0;
      drop_cnt    <= '0;
      kb_ovf_seen <= 1'b0;
    end else begin
      if (set_key) begin
        held[idx] <= 1'b1;
        held_cnt  <= held_cnt + 9'd1;
      end else if (clr_key) begin
        held[idx] <= 1'b0;
        held_cnt  <= held_cnt - 9'd1;
      end
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (kb_overflow)
        kb_ovf_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Directed bench for ps2_event_ctrl: fetch timing, decode, FIFO and reset.
// Expected events are hand-derived from the scan-code sequences driven.
module tb_ps2_event_ctrl;

  logic       mainclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] kb_data = '0;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic       ev_valid;
  logic       ev_ack = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [8:0] held_cnt;
  logic [7:0] drop_cnt;
  logic       kb_ovf_seen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cap = -100;

  always #5 mainclk = ~mainclk;
  always @(posedge mainclk) cyc++;

  ps2_event_ctrl #(
    .FIFO_DEPTH(8),
    .SUPPRESS_REPEAT(1)
  ) dut (
    .mainclk      (mainclk),
    .reset        (reset),
    .kb_data      (kb_data),
    .kb_ready     (kb_ready),
    .kb_overflow  (kb_overflow),
    .kb_nextdata_n(kb_nextdata_n),
    .ev_valid     (ev_valid),
    .ev_ack       (ev_ack),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .held_cnt     (held_cnt),
    .drop_cnt     (drop_cnt),
    .kb_ovf_seen  (kb_ovf_seen)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge that captured the byte (strobe low).
  task automatic start_byte(input logic [7:0] b);
    bit seen = 0;
    @(negedge mainclk);
    kb_data  = b;
    kb_ready = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge mainclk);
      #1;
      if (!kb_nextdata_n) seen = 1;
    end
    kb_ready = 1'b0;
    if (!seen) begin
      chk("pop_timeout", 32'd0, 32'd1);
    end else begin
      chk("pop_gap", 32'(cyc - last_cap >= 3), 32'd1);
      last_cap = cyc;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    start_byte(b);
    @(posedge mainclk);
    #1;
    chk("pop_width", 32'(kb_nextdata_n), 32'd1);
  endtask

  task automatic pop_ev(input string tag, input logic [9:0] exp);
    @(negedge mainclk);
    chk(tag, {21'd0, ev_valid, ev_ext, ev_break, ev_code}, {21'd0, 1'b1, exp});
    ev_ack = 1'b1;
    @(posedge mainclk);
    #1;
    ev_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mainclk);
    reset = 1'b1;
    repeat (2) @(posedge mainclk);
    @(negedge mainclk);
    reset = 1'b0;
    last_cap = -100;
  endtask

  task automatic chk_empty(input string tag);
    @(negedge mainclk);
    chk(tag, 32'(ev_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] seq[$];

    do_reset();
    @(negedge mainclk);
    chk("rst_nextdata", 32'(kb_nextdata_n), 32'd1);
    chk("rst_evout", {22'd0, ev_valid, ev_ext, ev_break, ev_code}, 32'd0);
    chk("rst_held", 32'(held_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(kb_ovf_seen), 32'd0);

    // Make then break of 1C
    send_byte(8'h1C);
    chk("held_1", 32'(held_cnt), 32'd1);
    pop_ev("ev_make1c", {2'b00, 8'h1C});
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("held_0", 32'(held_cnt), 32'd0);
    pop_ev("ev_brk1c", {2'b01, 8'h1C});
    chk_empty("empty_a");

    // Extended keys and typematic suppression
    seq = '{8'hE0, 8'h75, 8'h1C, 8'h1C, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) send_byte(seq[i]);
    chk("held_ext", 32'(held_cnt), 32'd1);
    pop_ev("ev_e075", {2'b10, 8'h75});
    pop_ev("ev_1c", {2'b00, 8'h1C});
    pop_ev("ev_e0f075", {2'b11, 8'h75});
    chk_empty("empty_b");
    send_byte(8'hF0);
    send_byte(8'h1C);
    pop_ev("ev_rel1c", {2'b01, 8'h1C});

    // Pause sequence swallowed
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    foreach (seq[i]) send_byte(seq[i]);
    chk("held_pause", 32'(held_cnt), 32'd1);
    pop_ev("ev_29", {2'b00, 8'h29});
    chk_empty("empty_c");
    send_byte(8'hF0);
    send_byte(8'h29);
    pop_ev("ev_rel29", {2'b01, 8'h29});

    // Overfill, then push coinciding with a pop on a full FIFO
    for (int k = 1; k <= 10; k++) send_byte(8'(k));
    chk("drop_2", 32'(drop_cnt), 32'd2);
    chk("held_10", 32'(held_cnt), 32'd10);
    start_byte(8'h0B);
    @(negedge mainclk);
    ev_ack = 1'b1;
    @(posedge mainclk);
    #1;
    ev_ack = 1'b0;
    chk("drop_still2", 32'(drop_cnt), 32'd2);
    chk("held_11", 32'(held_cnt), 32'd11);
    for (int k = 2; k <= 8; k++) pop_ev("ev_fifo", {2'b00, 8'(k)});
    pop_ev("ev_fifo_0b", {2'b00, 8'h0B});
    chk_empty("empty_d");

    // Spurious break, status byte, overflow flag
    do_reset();
    send_byte(8'hF0);
    send_byte(8'h5A);
    send_byte(8'hAA);
    chk_empty("empty_e");
    chk("held_spur", 32'(held_cnt), 32'd0);
    chk("ovf_pre", 32'(kb_ovf_seen), 32'd0);
    @(negedge mainclk);
    kb_overflow = 1'b1;
    @(negedge mainclk);
    kb_overflow = 1'b0;
    chk("ovf_set", 32'(kb_ovf_seen), 32'd1);
    repeat (3) @(negedge mainclk);
    chk("ovf_sticky", 32'(kb_ovf_seen), 32'd1);

    // Reset while in POP with events queued
    send_byte(8'h11);
    send_byte(8'h12);
    send_byte(8'h13);
    start_byte(8'h14);
    reset = 1'b1;
    @(posedge mainclk);
    #1;
    reset = 1'b0;
    chk("rpop_valid", 32'(ev_valid), 32'd0);
    chk("rpop_nextdata", 32'(kb_nextdata_n), 32'd1);
    chk("rpop_held", 32'(held_cnt), 32'd0);
    chk("rpop_ovf", 32'(kb_ovf_seen), 32'd0);
    @(negedge mainclk);
    kb_data  = 8'h15;
    kb_ready = 1'b1;
    @(posedge mainclk);
    #1;
    kb_ready = 1'b0;
    chk("rpop_idle", 32'(kb_nextdata_n), 32'd0);
    @(posedge mainclk);
    #1;
    pop_ev("ev_after_rst", {2'b00, 8'h15});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
